// File: rtl/scan_chain_shifter.sv
// Serial engine between the t0/t1 transfer FIFOs and a scan chain: pops words, shifts them
// LSB-first into the chain head, and packs the chain tail bits into words pushed to t1.
module scan_chain_shifter #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  output logic              done,
  input  logic              in_empty,
  output logic              in_rd_en,
  input  logic [WORD_W-1:0] in_data,
  input  logic              out_almost_full,
  output logic              out_wr_en,
  output logic [WORD_W-1:0] out_data,
  input  logic              scan_output,
  output logic              scan_input,
  output logic              scan_enable,
  output logic              scan_ck_enable
);

  localparam int unsigned CntW = $clog2(WORD_W + 1);
  localparam logic [CntW-1:0]  WordCnt = CntW'(WORD_W);
  localparam logic [LEN_W-1:0] WordLen = LEN_W'(WORD_W);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StShift,
    StWrite,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CntW-1:0]     wbits_q, wbits_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   cap_q, cap_d;

  logic                done_q, done_d;
  logic                in_rd_en_q, in_rd_en_d;
  logic                out_wr_en_q, out_wr_en_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                scan_input_q, scan_input_d;
  logic                scan_enable_q, scan_enable_d;
  logic                scan_ck_enable_q, scan_ck_enable_d;

  logic                fetch_ok;

  // We are the only reader of t0 and the only writer of t1, so a condition seen at an edge
  // still holds during the following registered pop cycle.
  assign fetch_ok = !in_empty && !out_almost_full;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    wbits_d    = wbits_q;
    shreg_d    = shreg_q;
    cap_d      = cap_q;
    out_data_d = out_data_q;
    in_rd_en_d = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          rem_d = length;
          if (length == '0) begin
            state_d = StDone;
          end else begin
            state_d    = StFetch;
            in_rd_en_d = fetch_ok;
          end
        end
      end
      StFetch: begin
        // in_rd_en_q high means the pop is in flight this cycle; data arrives in LOAD.
        if (in_rd_en_q) begin
          state_d = StLoad;
        end else begin
          in_rd_en_d = fetch_ok;
        end
      end
      StLoad: begin
        shreg_d = in_data;
        cnt_d   = (rem_q < WordLen) ? CntW'(rem_q) : WordCnt;
        wbits_d = cnt_d;
        cap_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        shreg_d = shreg_q >> 1;
        cap_d   = {scan_output, cap_q[WORD_W-1:1]};
        rem_d   = rem_q - LEN_W'(1);
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d    = StWrite;
          out_data_d = cap_d >> (WordCnt - wbits_q);
        end
      end
      StWrite: begin
        if (rem_q == '0) begin
          state_d = StDone;
        end else begin
          state_d    = StFetch;
          in_rd_en_d = fetch_ok;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    scan_enable_d    = state_d inside {StFetch, StLoad, StShift, StWrite};
    scan_ck_enable_d = (state_d == StShift);
    scan_input_d     = (state_d == StShift) ? shreg_d[0] : 1'b0;
    done_d           = (state_d == StDone);
    out_wr_en_d      = (state_d == StWrite);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q          <= StIdle;
      rem_q            <= '0;
      cnt_q            <= '0;
      wbits_q          <= '0;
      shreg_q          <= '0;
      cap_q            <= '0;
      done_q           <= 1'b0;
      in_rd_en_q       <= 1'b0;
      out_wr_en_q      <= 1'b0;
      out_data_q       <= '0;
      scan_input_q     <= 1'b0;
      scan_enable_q    <= 1'b0;
      scan_ck_enable_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      rem_q            <= rem_d;
      cnt_q            <= cnt_d;
      wbits_q          <= wbits_d;
      shreg_q          <= shreg_d;
      cap_q            <= cap_d;
      done_q           <= done_d;
      in_rd_en_q       <= in_rd_en_d;
      out_wr_en_q      <= out_wr_en_d;
      out_data_q       <= out_data_d;
      scan_input_q     <= scan_input_d;
      scan_enable_q    <= scan_enable_d;
      scan_ck_enable_q <= scan_ck_enable_d;
    end
  end

  assign done           = done_q;
  assign in_rd_en       = in_rd_en_q;
  assign out_wr_en      = out_wr_en_q;
  assign out_data       = out_data_q;
  assign scan_input     = scan_input_q;
  assign scan_enable    = scan_enable_q;
  assign scan_ck_enable = scan_ck_enable_q;

endmodule
